// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle main controller.
// Optional bne support is enabled by defining CTRL_BNE_EN.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StAluWb   = 4'd7,
    StImmEx   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpSlti  = 6'b001010;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluFunc = 3'b110;

  localparam logic [1:0] SrcBReg      = 2'b00;
  localparam logic [1:0] SrcBFour     = 2'b01;
  localparam logic [1:0] SrcBImm      = 2'b10;
  localparam logic [1:0] SrcBImmShift = 2'b11;

  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

`ifdef CTRL_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OpAddi) || (op == OpAndi) || (op == OpOri) ||
           (op == OpXori) || (op == OpSlti);
  endfunction

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OpBeq) || (BneEn && (op == OpBne));
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) || (op == OpJ) ||
           is_branch_op(op) || is_imm_op(op);
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] aop;
    aop = AluAdd;
    unique case (op)
      OpAndi:  aop = AluAnd;
      OpOri:   aop = AluOr;
      OpXori:  aop = AluXor;
      OpSlti:  aop = AluSlt;
      default: aop = AluAdd;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decoder: state plus latched opcode to datapath enables.
// Honours CTRL_BNE_EN through mc_ctrl_pkg::BneEn.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        // pc_write/ir_write are qualified with mem_ready in the top
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SrcBFour;
        ctrl_o.alu_op    = AluAdd;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SrcBImmShift;
        ctrl_o.alu_op    = AluAdd;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluAdd;
      end
      StMemRd: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      StRtypeEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBReg;
        ctrl_o.alu_op    = AluFunc;
      end
      StAluWb: begin
        // rd for R-type, rt for immediates
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = (opcode_i == OpRtype);
      end
      StImmEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = imm_alu_op(opcode_i);
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SrcBReg;
        ctrl_o.alu_op        = AluSub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PcSrcBranch;
        ctrl_o.branch_ne     = BneEn && (opcode_i == OpBne);
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSrcJump;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main controller: state register, opcode latch, sequencing and reset gating.
// Define CTRL_BNE_EN to decode bne (000101) as a branch with branch_ne set.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       illegal_op
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  ctrl_t      ctrl_dec;
  ctrl_t      ctrl_out;

  mc_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode_q),
    .ctrl_o   (ctrl_dec)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        opcode_d = opcode;
        if (opcode == OpRtype) begin
          state_d = StRtypeEx;
        end else if ((opcode == OpLw) || (opcode == OpSw)) begin
          state_d = StMemAdr;
        end else if (is_branch_op(opcode)) begin
          state_d = StBranch;
        end else if (opcode == OpJ) begin
          state_d = StJump;
        end else if (is_imm_op(opcode)) begin
          state_d = StImmEx;
        end else begin
          state_d = StFetch;
        end
      end
      StMemAdr:  state_d = (opcode_q == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StRtypeEx: state_d = StAluWb;
      StImmEx:   state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // PC and IR only update on the cycle the fetch completes; reset silences everything.
  always_comb begin
    ctrl_out = ctrl_dec;
    if ((state_q == StFetch) && !mem_ready) begin
      ctrl_out.pc_write = 1'b0;
      ctrl_out.ir_write = 1'b0;
    end
    if (rst) ctrl_out = '0;
  end

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign branch_ne     = ctrl_out.branch_ne;
  assign iord          = ctrl_out.iord;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign pc_source     = ctrl_out.pc_source;
  assign alu_op        = ctrl_out.alu_op;

  assign illegal_op = !rst && (state_q == StDecode) && !op_legal(opcode);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Testbench for mc_main_ctrl: per-instruction expected traces, cycle-count table,
// reset corner cases and randomized instruction streams.
module tb_mc_main_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } exp_t;

  typedef struct {
    string      tag;
    logic [5:0] op;
    logic       rdy;
    exp_t       exp;
  } step_t;

  typedef struct {
    logic [5:0] op;
    int         cycles;
  } cnt_vec_t;

`ifdef CTRL_BNE_EN
  localparam bit BneOn = 1'b1;
`else
  localparam bit BneOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  exp_t       dut;

  int checks = 0;
  int errors = 0;
  step_t trace_q[$];

  mc_main_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  assign dut = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op,
                illegal_op};

  // Instruction class: 0 R-type, 1 lw, 2 sw, 3 branch, 4 jump, 5 immediate, 6 illegal.
  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000101: return BneOn ? 3 : 6;
      6'b000010: return 4;
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: return 5;
      default:   return 6;
    endcase
  endfunction

  function automatic logic [2:0] imm_aop(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b010;
      6'b001101: return 3'b011;
      6'b001110: return 3'b100;
      6'b001010: return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = '0;
    e.mem_read  = 1'b1;
    e.ir_write  = rdy;
    e.pc_write  = rdy;
    e.alu_src_b = 2'b01;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [1:0] srcb, input logic [2:0] aop);
    exp_t e = '0;
    e.alu_src_a = 1'b1;
    e.alu_src_b = srcb;
    e.alu_op    = aop;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic m2r, input logic rdst);
    exp_t e = '0;
    e.reg_write  = 1'b1;
    e.mem_to_reg = m2r;
    e.reg_dst    = rdst;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic wr);
    exp_t e = '0;
    e.iord      = 1'b1;
    e.mem_read  = !wr;
    e.mem_write = wr;
    return e;
  endfunction

  task automatic push(input string tag, input logic [5:0] op, input logic rdy, input exp_t e);
    step_t s;
    s.tag = tag; s.op = op; s.rdy = rdy; s.exp = e;
    trace_q.push_back(s);
  endtask

  // Expected per-cycle behaviour of one instruction; non-DECODE cycles see a noise opcode.
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    exp_t e;
    int   cls;
    cls = op_class(op);
    trace_q.delete();
    for (int i = 0; i < fw; i++) push("FETCH_WAIT", 6'($urandom), 1'b0, e_fetch(1'b0));
    push("FETCH", 6'($urandom), 1'b1, e_fetch(1'b1));
    e = '0;
    e.alu_src_b  = 2'b11;
    e.illegal_op = (cls == 6);
    push("DECODE", op, 1'($urandom), e);
    case (cls)
      0: begin
        push("RTYPE_EX", 6'($urandom), 1'($urandom), e_exec(2'b00, 3'b110));
        push("ALUWB_R", 6'($urandom), 1'($urandom), e_wb(1'b0, 1'b1));
      end
      1, 2: begin
        push("MEMADR", 6'($urandom), 1'($urandom), e_exec(2'b10, 3'b000));
        for (int i = 0; i < mw; i++)
          push((cls == 1) ? "MEMRD_WAIT" : "MEMWR_WAIT", 6'($urandom), 1'b0, e_mem(cls == 2));
        push((cls == 1) ? "MEMRD" : "MEMWR", 6'($urandom), 1'b1, e_mem(cls == 2));
        if (cls == 1) push("MEMWB", 6'($urandom), 1'($urandom), e_wb(1'b1, 1'b0));
      end
      3: begin
        e = e_exec(2'b00, 3'b001);
        e.pc_write_cond = 1'b1;
        e.pc_source     = 2'b01;
        e.branch_ne     = (op == 6'b000101);
        push("BRANCH", 6'($urandom), 1'($urandom), e);
      end
      4: begin
        e = '0;
        e.pc_write  = 1'b1;
        e.pc_source = 2'b10;
        push("JUMP", 6'($urandom), 1'($urandom), e);
      end
      5: begin
        push("IMM_EX", 6'($urandom), 1'($urandom), e_exec(2'b10, imm_aop(op)));
        push("ALUWB_I", 6'($urandom), 1'($urandom), e_wb(1'b0, 1'b0));
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input exp_t e);
    checks++;
    if (dut !== e) begin
      errors++;
      $display("FAIL %s: got %05h required %05h (t=%0t)", tag, dut, e, $time);
    end
  endtask

  // Expects to start just after a rising edge with the DUT in FETCH.
  task automatic apply(input int limit);
    int n;
    n = (limit < trace_q.size()) ? limit : trace_q.size();
    for (int i = 0; i < n; i++) begin
      opcode    = trace_q[i].op;
      mem_ready = trace_q[i].rdy;
      @(negedge clk);
      check(trace_q[i].tag, trace_q[i].exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    build(op, fw, mw);
    apply(trace_q.size());
  endtask

  // Counts cycles until the next completing fetch, holding mem_ready high.
  task automatic run_count(input logic [5:0] op, input int want);
    int  got;
    bit  found;
    got = 0; found = 1'b0;
    opcode = op; mem_ready = 1'b1;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      if (k > 1 && ir_write === 1'b1) begin
        found = 1'b1;
        got   = k - 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!found || got != want) begin
      errors++;
      $display("FAIL cycles op=%06b: got %0d required %0d", op, got, want);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  cnt_vec_t cnt_tab[12];
  logic [5:0] legal_ops[12];

  initial begin
    cnt_tab[0]  = '{6'b000000, 4};
    cnt_tab[1]  = '{6'b100011, 5};
    cnt_tab[2]  = '{6'b101011, 4};
    cnt_tab[3]  = '{6'b000100, 3};
    cnt_tab[4]  = '{6'b000010, 3};
    cnt_tab[5]  = '{6'b001000, 4};
    cnt_tab[6]  = '{6'b001100, 4};
    cnt_tab[7]  = '{6'b001101, 4};
    cnt_tab[8]  = '{6'b001110, 4};
    cnt_tab[9]  = '{6'b001010, 4};
    cnt_tab[10] = '{6'b000101, BneOn ? 3 : 2};
    cnt_tab[11] = '{6'b111111, 2};
    for (int i = 0; i < 12; i++) legal_ops[i] = cnt_tab[i].op;

    // Power-on reset
    rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("reset_outputs", '0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;

    // Cycle counts with mem_ready held high
    foreach (cnt_tab[i]) run_count(cnt_tab[i].op, cnt_tab[i].cycles);

    // Full per-cycle traces: add/lw/sw pipeline, lw with a 3-cycle stall, immediates, beq, j
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b100011, 0, 3);
    for (int i = 5; i < 10; i++) run_instr(legal_ops[i], 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b000101, 1, 0);
    run_instr(6'b110000, 0, 0);

    // Reset for two cycles while stalled in MEMRD, with mem_ready high to tempt completion
    build(6'b100011, 0, 5);
    apply(4);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_memrd_c1", '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_memrd_c2", '0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("post_rst_fetch", e_fetch(1'b0));
    @(posedge clk); #1;

    // Reset during a completing sw write: no write may be issued
    build(6'b101011, 0, 2);
    apply(4);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_memwr", '0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 10)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
